// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the user-mode trap sequencer:
// FSM encoding, cause codes, ustatus bit positions and utvec modes.
package trap_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_RETURN,
        ST_REDIRECT
    } state_e;

    localparam logic [4:0] EXC_ILLEGAL     = 5'd2;
    localparam logic [4:0] EXC_LD_MISALIGN = 5'd4;
    localparam logic [4:0] EXC_LD_FAULT    = 5'd5;
    localparam logic [4:0] EXC_ST_MISALIGN = 5'd6;
    localparam logic [4:0] EXC_ST_FAULT    = 5'd7;

    localparam logic [4:0] IRQ_SOFT  = 5'd0;
    localparam logic [4:0] IRQ_TIMER = 5'd4;
    localparam logic [4:0] IRQ_EXT   = 5'd8;

    localparam int USTATUS_UIE  = 0;
    localparam int USTATUS_UPIE = 4;

    localparam logic [1:0] UTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] UTVEC_VECTORED = 2'd1;

    // Causes whose tval is the faulting data address.
    function automatic logic tval_is_addr(input logic [4:0] code);
        return (code == EXC_LD_MISALIGN) || (code == EXC_LD_FAULT) ||
               (code == EXC_ST_MISALIGN) || (code == EXC_ST_FAULT);
    endfunction

endpackage

// File: rtl/trap_cause_select.sv
// Combinational trap arbitration: exception over interrupts,
// and among interrupts external > software > timer.
module trap_cause_select
    import trap_sequencer_pkg::*;
(
    input  logic       uie,
    input  logic       en_soft,
    input  logic       en_timer,
    input  logic       en_ext,
    input  logic       soft_irq,
    input  logic       timer_irq,
    input  logic       ext_irq,
    input  logic       exc_req,
    input  logic [4:0] exc_code,
    output logic       trap_valid,
    output logic       trap_is_irq,
    output logic [4:0] trap_code
);

    logic soft_act;
    logic timer_act;
    logic ext_act;

    assign soft_act  = uie & en_soft  & soft_irq;
    assign timer_act = uie & en_timer & timer_irq;
    assign ext_act   = uie & en_ext   & ext_irq;

    // Pick the single highest-priority pending trap source.
    always_comb begin
        trap_valid  = 1'b1;
        trap_is_irq = 1'b0;
        trap_code   = 5'd0;
        if (exc_req) begin
            trap_code = exc_code;
        end else if (ext_act) begin
            trap_is_irq = 1'b1;
            trap_code   = IRQ_EXT;
        end else if (soft_act) begin
            trap_is_irq = 1'b1;
            trap_code   = IRQ_SOFT;
        end else if (timer_act) begin
            trap_is_irq = 1'b1;
            trap_code   = IRQ_TIMER;
        end else begin
            trap_valid = 1'b0;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// User-mode trap entry / URET sequencer: captures the event at commit,
// writes the CSR bundle, then redirects and flushes the pipeline.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iValid,
    input  logic [XLEN-1:0] iPC,
    input  logic [31:0]     iInstr,
    input  logic            iExcReq,
    input  logic [4:0]      iExcCode,
    input  logic [XLEN-1:0] iExcTval,
    input  logic            iUret,
    input  logic            iSoftIrq,
    input  logic            iTimerIrq,
    input  logic            iExtIrq,
    input  logic [XLEN-1:0] iUstatus,
    input  logic [XLEN-1:0] iUie,
    input  logic [XLEN-1:0] iUtvec,
    input  logic [XLEN-1:0] iUepc,
    output logic            oCSRWrite,
    output logic [XLEN-1:0] oUcause,
    output logic [XLEN-1:0] oUepc,
    output logic [XLEN-1:0] oUtval,
    output logic [XLEN-1:0] oUstatus,
    output logic            oStall,
    output logic            oFlush,
    output logic            oRedirect,
    output logic [XLEN-1:0] oRedirectPC
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] ustatus_q, ustatus_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            csr_write_q, csr_write_d;
    logic            redirect_q, redirect_d;
    logic            flush_q, flush_d;

    logic            trap_valid;
    logic            trap_is_irq;
    logic [4:0]      trap_code;
    logic            idle;
    logic            trap_accept;
    logic            uret_accept;
    logic [XLEN-1:0] tvec_base;
    logic            unused_uie;

    assign unused_uie = ^{iUie[XLEN-1:9], iUie[7:5], iUie[3:1]};

    trap_cause_select u_sel (
        .uie         (iUstatus[USTATUS_UIE]),
        .en_soft     (iUie[0]),
        .en_timer    (iUie[4]),
        .en_ext      (iUie[8]),
        .soft_irq    (iSoftIrq),
        .timer_irq   (iTimerIrq),
        .ext_irq     (iExtIrq),
        .exc_req     (iExcReq),
        .exc_code    (iExcCode),
        .trap_valid  (trap_valid),
        .trap_is_irq (trap_is_irq),
        .trap_code   (trap_code)
    );

    assign idle        = (state_q == ST_IDLE);
    assign trap_accept = idle & iValid & trap_valid;
    assign uret_accept = idle & iValid & ~trap_valid & iUret;
    assign tvec_base   = {iUtvec[XLEN-1:2], 2'b00};

    // Next-state and capture of the CSR bundle and redirect target.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        tval_d      = tval_q;
        ustatus_d   = ustatus_q;
        target_d    = target_q;
        csr_write_d = 1'b0;
        redirect_d  = 1'b0;
        flush_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trap_accept) begin
                    state_d     = ST_ENTRY;
                    csr_write_d = 1'b1;
                    epc_d       = iPC;
                    ustatus_d   = iUstatus;
                    ustatus_d[USTATUS_UPIE] = iUstatus[USTATUS_UIE];
                    ustatus_d[USTATUS_UIE]  = 1'b0;
                    if (trap_is_irq) begin
                        cause_d = {1'b1, (XLEN-1)'(trap_code)};
                        tval_d  = '0;
                    end else begin
                        cause_d = XLEN'(trap_code);
                        if (trap_code == EXC_ILLEGAL)
                            tval_d = XLEN'(iInstr);
                        else if (tval_is_addr(trap_code))
                            tval_d = iExcTval;
                        else
                            tval_d = '0;
                    end
                    if (iUtvec[1:0] == UTVEC_VECTORED && trap_is_irq)
                        target_d = tvec_base + XLEN'({trap_code, 2'b00});
                    else
                        target_d = tvec_base;
                end else if (uret_accept) begin
                    state_d     = ST_RETURN;
                    csr_write_d = 1'b1;
                    epc_d       = iUepc;
                    ustatus_d   = iUstatus;
                    ustatus_d[USTATUS_UIE]  = iUstatus[USTATUS_UPIE];
                    ustatus_d[USTATUS_UPIE] = 1'b1;
                    target_d    = {iUepc[XLEN-1:1], 1'b0};
                end
            end
            ST_ENTRY, ST_RETURN: begin
                state_d    = ST_REDIRECT;
                redirect_d = 1'b1;
                flush_d    = 1'b1;
            end
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any sequence.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            cause_q     <= '0;
            epc_q       <= '0;
            tval_q      <= '0;
            ustatus_q   <= '0;
            target_q    <= '0;
            csr_write_q <= 1'b0;
            redirect_q  <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            tval_q      <= tval_d;
            ustatus_q   <= ustatus_d;
            target_q    <= target_d;
            csr_write_q <= csr_write_d;
            redirect_q  <= redirect_d;
            flush_q     <= flush_d;
        end
    end

    assign oCSRWrite   = csr_write_q;
    assign oUcause     = cause_q;
    assign oUepc       = epc_q;
    assign oUtval      = tval_q;
    assign oUstatus    = ustatus_q;
    assign oRedirect   = redirect_q;
    assign oFlush      = flush_q;
    assign oRedirectPC = target_q;
    assign oStall      = ~idle | trap_accept | uret_accept;

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter: XLEN, 32, data/address width.
REQ-002 SHALL have port: iCLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: iRST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: iValid input 1 (commit-stage instruction valid); iPC input XLEN (commit PC); iInstr input 32 (commit instruction).
REQ-005 SHALL have ports: iExcReq input 1 (synchronous exception); iExcCode input 5 (exception cause); iExcTval input XLEN (faulting address).
REQ-006 SHALL have ports: iUret input 1 (URET at commit); iSoftIrq, iTimerIrq, iExtIrq input 1 each (raw interrupt lines).
REQ-007 SHALL have ports: iUstatus, iUie, iUtvec, iUepc input XLEN (current CSR values).
REQ-008 SHALL have ports: oCSRWrite output 1; oUcause, oUepc, oUtval, oUstatus output XLEN (CSR update bundle).
REQ-009 SHALL have ports: oStall output 1; oFlush output 1; oRedirect output 1; oRedirectPC output XLEN.

Function
REQ-010 SHALL implement FSM states IDLE, ENTRY, RETURN, REDIRECT.
REQ-011 In IDLE with iValid=1, SHALL accept exactly one event per cycle, priority: iExcReq > enabled interrupt > iUret.
REQ-012 Interrupt k SHALL be enabled iff iUstatus[0] (UIE)=1, its iUie bit is set, and its line is high; bits: soft 0, timer 4, external 8.
REQ-013 Interrupt priority SHALL be external > soft > timer; oUcause SHALL be {1'b1, code} with bit XLEN-1 set.
REQ-014 Exception oUcause SHALL be zero-extended iExcCode; oUtval SHALL be iInstr when code=2, iExcTval when code in {4,5,6,7}, else 0.
REQ-015 Interrupt oUtval SHALL be 0; oUepc SHALL be iPC for all traps (faulting or not-yet-executed instruction).
REQ-016 Trap accepted at cycle N: ENTRY at N+1 with oCSRWrite=1 for one cycle, oUstatus = iUstatus with bit4 (UPIE)<=UIE and bit0 (UIE)<=0.
REQ-017 URET accepted at N: RETURN at N+1 with oCSRWrite=1, oUstatus = iUstatus with UIE<=UPIE and UPIE<=1; oUcause/oUepc/oUtval SHALL hold the iUcause-independent current values (oUepc=iUepc).
REQ-018 REDIRECT at N+2: oRedirect=1 and oFlush=1 for exactly one cycle; back to IDLE at N+3.
REQ-019 Trap target: iUtvec[1:0]=0 -> {iUtvec[XLEN-1:2],2'b00}; iUtvec[1:0]=1 and interrupt -> base + 4*code; iUtvec[1:0]=1 and exception -> base; values 2,3 SHALL be treated as 0.
REQ-020 URET target SHALL be iUepc with bit0 cleared; address arithmetic SHALL wrap modulo 2^XLEN.
REQ-021 Target, cause, epc, tval SHALL be registered at acceptance; input changes during ENTRY/RETURN/REDIRECT SHALL not affect them.
REQ-022 oStall SHALL be 1 in every non-IDLE state and on the acceptance cycle; events arriving while non-IDLE SHALL be ignored.
REQ-023 iValid=0 SHALL suppress all acceptance, including pending interrupts.
REQ-024 oCSRWrite, oRedirect, oFlush SHALL never be high in the same cycle.

Reset
REQ-025 iRST=1 at an edge SHALL force IDLE and zero all outputs in the following cycle, aborting any sequence in progress without emitting oCSRWrite or oRedirect.
REQ-026 After reset release, the first acceptance SHALL be possible on the next edge.

Structure
REQ-027 A shared package SHALL hold FSM state encoding, cause codes (2,4-7, interrupt 0/4/8), ustatus bit positions (UIE=0, UPIE=4), utvec mode values.
REQ-028 Interrupt priority/cause selection SHALL be a combinational sub-module trap_cause_select.

Verification
REQ-029 Illegal instr: iExcReq=1, code 2, iPC=0x00400010, iInstr=0xFFFFFFFF, iUtvec=0x00400100 -> N+1 ucause=2, uepc=0x00400010, utval=0xFFFFFFFF; N+2 redirect 0x00400100.
REQ-030 Vectored timer irq: UIE=1, iUie=0x10, iTimerIrq=1, iUtvec=0x00400101 -> ucause=0x80000004, utval=0, target 0x00400110, UPIE=1, UIE=0.
REQ-031 Simultaneous iExcReq (code 5, tval 0x10010003), iExtIrq, iUret -> exception wins; ucause=5, utval=0x10010003.
REQ-032 URET: iUstatus=0x10, iUepc=0x00400025 -> oUstatus=0x11, redirect 0x00400024, no trap CSR change.
REQ-033 UIE=0 with all irq lines high -> no acceptance, oStall=0; iRST asserted in ENTRY -> IDLE, no oRedirect pulse.
